// File: rtl/muldiv_scheduler_pkg.sv
// Shared encodings for the E-stage multiply/divide scheduler.
//   md_op encodings : MD_NONE .. MD_MTLO (MD_RSVD behaves as MD_NONE)
//   FSM encodings   : ST_IDLE, ST_MUL, ST_DIV
//   Default busy-cycle counts for mult/multu and div/divu.
package muldiv_scheduler_pkg;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;
    localparam logic [2:0] MD_RSVD  = 3'd7;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;

    localparam int unsigned DEFAULT_MULT_CYCLES = 5;
    localparam int unsigned DEFAULT_DIV_CYCLES  = 10;

    // Any op that touches HI/LO (mult, multu, div, divu, mthi, mtlo).
    function automatic logic is_md_op(input logic [2:0] op);
        return (op != MD_NONE) && (op != MD_RSVD);
    endfunction

    // Ops that occupy the multi-cycle unit.
    function automatic logic is_arith_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_alu.sv
// Combinational multiply/divide datapath.
//   op          : md_op encoding (only mult/multu/div/divu produce results)
//   a, b        : operands (rs, rt)
//   hi_res      : product high word, or remainder
//   lo_res      : product low word, or quotient
//   div_by_zero : div/divu with b == 0; caller must leave HI/LO untouched
module muldiv_alu
    import muldiv_scheduler_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi_res,
    output logic [31:0] lo_res,
    output logic        div_by_zero
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] divisor;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    always_comb begin
        prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        prod_u = {32'd0, a} * {32'd0, b};

        // Signed division via magnitudes: quotient truncates toward zero and the
        // remainder follows the dividend. 0x80000000 / -1 wraps to 0x80000000.
        a_neg   = (op == MD_DIV) && a[31];
        b_neg   = (op == MD_DIV) && b[31];
        mag_a   = a_neg ? (~a + 32'd1) : a;
        mag_b   = b_neg ? (~b + 32'd1) : b;
        // Guard keeps the divider defined; the result is discarded on divide by zero.
        divisor = (mag_b == 32'd0) ? 32'd1 : mag_b;
        q_mag   = mag_a / divisor;
        r_mag   = mag_a % divisor;
        quot    = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        rem     = a_neg ? (~r_mag + 32'd1) : r_mag;

        div_by_zero = ((op == MD_DIV) || (op == MD_DIVU)) && (b == 32'd0);

        hi_res = 32'd0;
        lo_res = 32'd0;
        case (op)
            MD_MULT: begin
                hi_res = prod_s[63:32];
                lo_res = prod_s[31:0];
            end
            MD_MULTU: begin
                hi_res = prod_u[63:32];
                lo_res = prod_u[31:0];
            end
            MD_DIV, MD_DIVU: begin
                hi_res = rem;
                lo_res = quot;
            end
            default: begin
                hi_res = 32'd0;
                lo_res = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/muldiv_scheduler.sv
// E-stage multiply/divide scheduler with the HI/LO register pair.
//   clk, reset          : clock, asynchronous active-low reset
//   md_op_E, A_E, B_E   : op and forwarded operands in E
//   cancel              : exception taken this cycle, blocks issue
//   md_use_D            : D instruction reads/writes the md unit
//   busy                : multi-cycle op in flight
//   start               : a mult/div issues this cycle
//   stall_md            : stall request for D
//   HI, LO              : architectural HI/LO
// The result is computed at issue and held in pending registers; the busy counter
// only models latency. HI/LO change at the final busy edge or on mthi/mtlo.
module muldiv_scheduler
    import muldiv_scheduler_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = DEFAULT_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = DEFAULT_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  md_op_E,
    input  logic [31:0] A_E,
    input  logic [31:0] B_E,
    input  logic        cancel,
    input  logic        md_use_D,
    output logic        busy,
    output logic        start,
    output logic        stall_md,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

    logic [1:0]  state_q, state_d;
    logic [3:0]  count_q, count_d;
    logic [31:0] hi_pend_q, hi_pend_d;
    logic [31:0] lo_pend_q, lo_pend_d;
    logic        dbz_q, dbz_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic [31:0] alu_hi;
    logic [31:0] alu_lo;
    logic        alu_dbz;
    logic        issue;

    muldiv_alu u_alu (
        .op          (md_op_E),
        .a           (A_E),
        .b           (B_E),
        .hi_res      (alu_hi),
        .lo_res      (alu_lo),
        .div_by_zero (alu_dbz)
    );

    always_comb begin
        busy     = (state_q != ST_IDLE);
        issue    = is_md_op(md_op_E) && !cancel && !busy;
        start    = issue && is_arith_op(md_op_E);
        stall_md = md_use_D && (start || busy);
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        hi_pend_d = hi_pend_q;
        lo_pend_d = lo_pend_q;
        dbz_d     = dbz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        if (busy) begin
            // An op arriving while busy is ignored; D is stalled so it should not happen.
            if (count_q == 4'd1) begin
                state_d = ST_IDLE;
                count_d = 4'd0;
                if (!dbz_q) begin
                    hi_d = hi_pend_q;
                    lo_d = lo_pend_q;
                end
            end else begin
                count_d = count_q - 4'd1;
            end
        end else if (issue) begin
            case (md_op_E)
                MD_MULT, MD_MULTU: begin
                    state_d   = ST_MUL;
                    count_d   = MULT_N;
                    hi_pend_d = alu_hi;
                    lo_pend_d = alu_lo;
                    dbz_d     = 1'b0;
                end
                MD_DIV, MD_DIVU: begin
                    state_d   = ST_DIV;
                    count_d   = DIV_N;
                    hi_pend_d = alu_hi;
                    lo_pend_d = alu_lo;
                    dbz_d     = alu_dbz;
                end
                MD_MTHI: hi_d = A_E;
                MD_MTLO: lo_d = A_E;
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            count_q   <= 4'd0;
            hi_pend_q <= 32'd0;
            lo_pend_q <= 32'd0;
            dbz_q     <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            hi_pend_q <= hi_pend_d;
            lo_pend_q <= lo_pend_d;
            dbz_q     <= dbz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign HI = hi_q;
    assign LO = lo_q;

endmodule
